// File: rtl/seg_scan_mux.sv
// Four-digit seven-segment scan driver: holds a 16-bit value and time-multiplexes
// its nibbles onto one hex bus with active-low anodes, decimal point and blanking.
module seg_scan_mux #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_CYC   = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] data_in,
  input  logic [3:0]  dp_in,
  input  logic        load,
  input  logic [3:0]  en,
  input  logic        lzb,
  output logic [3:0]  anode,
  output logic [3:0]  hex,
  output logic        dp,
  output logic [1:0]  digit
);

  localparam int            CW        = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYC);

  logic [15:0]   data_r;
  logic [3:0]    dp_r;
  logic [CW-1:0] cnt_r;
  logic [1:0]    idx_r;
  logic [3:0]    anode_r;
  logic [3:0]    hex_r;
  logic          dp_out_r;
  logic [1:0]    digit_r;

  logic          lit_s;
  logic [3:0]    hex_s;
  logic [3:0]    anode_s;
  logic          dp_s;

  // A digit is leading-zero blanked when it and every more significant nibble are zero.
  function automatic logic lzb_blank(input logic [15:0] d, input logic [1:0] i);
    logic b;
    case (i)
      2'd3:    b = (d[15:12] == 4'h0);
      2'd2:    b = (d[15:8]  == 8'h00);
      2'd1:    b = (d[15:4]  == 12'h000);
      default: b = 1'b0;
    endcase
    return b;
  endfunction

  // Holding register for the displayed value and decimal points.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_r <= 16'h0000;
      dp_r   <= 4'b0000;
    end else if (load) begin
      data_r <= data_in;
      dp_r   <= dp_in;
    end
  end

  // Slot counter and digit index; free-running regardless of load/en/lzb.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_r <= '0;
      idx_r <= 2'd0;
    end else if (cnt_r == CNT_LAST) begin
      cnt_r <= '0;
      idx_r <= idx_r + 2'd1;
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

  // Next output values derived from the current slot and held data.
  always_comb begin
    hex_s   = data_r[3:0];
    lit_s   = 1'b0;
    anode_s = 4'b1111;
    dp_s    = 1'b1;
    case (idx_r)
      2'd1:    hex_s = data_r[7:4];
      2'd2:    hex_s = data_r[11:8];
      2'd3:    hex_s = data_r[15:12];
      default: hex_s = data_r[3:0];
    endcase
    lit_s = en[idx_r] && !(lzb && lzb_blank(data_r, idx_r)) && (cnt_r >= CNT_BLANK);
    if (lit_s) begin
      anode_s = ~(4'b0001 << idx_r);
      dp_s    = ~dp_r[idx_r];
    end else begin
      anode_s = 4'b1111;
      dp_s    = 1'b1;
    end
  end

  // Output registers: one-cycle lag behind the internal scan state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      anode_r  <= 4'b1111;
      hex_r    <= 4'h0;
      dp_out_r <= 1'b1;
      digit_r  <= 2'd0;
    end else begin
      anode_r  <= anode_s;
      hex_r    <= hex_s;
      dp_out_r <= dp_s;
      digit_r  <= idx_r;
    end
  end

  assign anode = anode_r;
  assign hex   = hex_r;
  assign dp    = dp_out_r;
  assign digit = digit_r;

endmodule
